// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// The master side (the datapath) supplies ID/EX information. The slave side
// (hazard_ctrl) returns the write enables, the bubble/flush controls and the stall counter.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Valid/ready note: there is no handshake here. Every signal is a
  // level that is sampled on each rising clock edge. The control outputs refer
  // to the same cycle as the inputs that produced them.
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [5:0]       ex_operation;
  logic [4:0]       ex_rd;
  logic             ex_branch_tk;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic             state_dbg;      // 1 while the FSM is in its MDU state

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_operation, ex_rd, ex_branch_tk,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    input  mdu_busy, stall_cycles, state_dbg
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_operation, ex_rd, ex_branch_tk,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    output mdu_busy, stall_cycles, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for PC, IF/ID and ID/EX.
// The block handles load-use stalls, multi-cycle MDU occupancy of EX and taken-branch flushes.
// All controls are combinational from the state, the counter and the inputs.
// The block also keeps a saturating count of cycles in which the PC is held.
module hazard_ctrl #(
  parameter int          MDU_CYCLES = 4,
  parameter logic [5:0]  MDU_OP     = 6'b011100,
  parameter logic [5:0]  LW_OP      = 6'b100011,
  parameter logic [5:0]  NOOP_OP    = 6'b111111,
  parameter int          CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,   // asynchronous, active low
  hazard_ctrl_if.slave  hz
);

  localparam int CNT_BITS = $clog2(MDU_CYCLES + 1);
  localparam bit MDU_STALLS = (MDU_CYCLES > 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    CNT_BITS'((MDU_CYCLES > 1) ? (MDU_CYCLES - 2) : 0);

  typedef enum logic {RUN = 1'b0, MDU = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  logic pc_write_c, if_id_write_c, if_id_flush_c;
  logic id_ex_write_c, id_ex_bubble_c, mdu_busy_c;
  logic load_use;
  logic mdu_in_ex;

  // A load whose destination is read by the ID instruction. Register 0 never creates a hazard.
  assign load_use = (hz.ex_operation == LW_OP) && (hz.ex_operation != NOOP_OP) &&
                    (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  assign mdu_in_ex = MDU_STALLS && (hz.ex_operation == MDU_OP) &&
                     (hz.ex_operation != NOOP_OP);

  // Next-state and same-cycle controls. While reset is held, the controls keep their pass-through values.
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_write_c  = 1'b1;
    id_ex_bubble_c = 1'b0;
    mdu_busy_c     = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    if (rst) begin
      case (state_q)
        RUN: begin
          if (hz.ex_branch_tk) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
          end else if (mdu_in_ex) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_write_c = 1'b0;
            mdu_busy_c    = 1'b1;
            state_d       = MDU;
            cnt_d         = CNT_LOAD;
          end else if (load_use) begin
            // The lw moves on to MEM at this edge, so a single bubble clears the hazard.
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
          end
        end
        MDU: begin
          if (cnt_q != '0) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_write_c = 1'b0;
            mdu_busy_c    = 1'b1;
            cnt_d         = cnt_q - 1'b1;
          end else begin
            // In the release cycle the MDU op leaves EX and the pipeline advances.
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_d = stall_q;
    if (!pc_write_c && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // FSM state, MDU down-counter and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_write  = id_ex_write_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.mdu_busy     = mdu_busy_c;
  assign hz.stall_cycles = stall_q;
  assign hz.state_dbg    = (state_q == MDU);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// The bench runs directed scenarios followed by randomized traffic.
// The reference model tracks how long an MDU op has been in EX and keeps an unbounded stall tally.
// A second instance with a narrow counter is used to exercise saturation.
module tb_hazard_ctrl;
  localparam int         MDU_CYCLES = 4;
  localparam int         SAT_W      = 4;
  localparam logic [5:0] MDU_OP     = 6'b011100;
  localparam logic [5:0] LW_OP      = 6'b100011;
  localparam logic [5:0] NOOP_OP    = 6'b111111;
  localparam logic [5:0] ADD_OP     = 6'b000000;
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mdu_busy}
  localparam logic [5:0] O_PASS  = 6'b110100;
  localparam logic [5:0] O_FLUSH = 6'b111110;
  localparam logic [5:0] O_MDU   = 6'b000001;
  localparam logic [5:0] O_LU    = 6'b000110;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16))    hif ();
  hazard_ctrl_if #(.CNT_W(SAT_W)) sif ();

  hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .hz (hif.slave));
  hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(SAT_W)) dut_sat (
    .clk (clk), .rst (rst), .hz (sif.slave));

  assign sif.id_rs        = hif.id_rs;
  assign sif.id_rt        = hif.id_rt;
  assign sif.id_uses_rt   = hif.id_uses_rt;
  assign sif.ex_operation = hif.ex_operation;
  assign sif.ex_rd        = hif.ex_rd;
  assign sif.ex_branch_tk = hif.ex_branch_tk;

  // scoreboard
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int age      = 0;  // cycles the current MDU op has already spent in EX (0 = none)
  int raw      = 0;  // stall cycles since reset, unbounded

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_cnt(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Reference model: the expected controls for the current inputs.
  task automatic model_eval(output logic [5:0] e, output int age_n);
    logic hit;
    age_n = age;
    hit = (hif.ex_operation == LW_OP) && (hif.ex_rd != 0) &&
          ((hif.ex_rd == hif.id_rs) || (hif.id_uses_rt && hif.ex_rd == hif.id_rt));
    if (!rst) begin
      e = O_PASS; age_n = 0;
    end else if (age > 0) begin
      // The op occupies EX for MDU_CYCLES cycles. Its final cycle releases the pipeline.
      if (age == MDU_CYCLES - 1) begin e = O_PASS; age_n = 0; end
      else begin e = O_MDU; age_n = age + 1; end
    end else if (hif.ex_branch_tk) begin
      e = O_FLUSH;
    end else if (hif.ex_operation == MDU_OP && MDU_CYCLES > 1) begin
      e = O_MDU; age_n = 1;
    end else if (hit) begin
      e = O_LU;
    end else begin
      e = O_PASS;
    end
  endtask

  // driver tasks
  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br);
    hif.ex_operation = op;
    hif.ex_rd        = rd;
    hif.id_rs        = rs;
    hif.id_rt        = rt;
    hif.id_uses_rt   = urt;
    hif.ex_branch_tk = br;
  endtask

  // One clock: check at the falling edge, advance the model, then wait for the rising edge.
  task automatic cycle(input string tag);
    logic [5:0] e;
    logic [5:0] got;
    int age_n;
    @(negedge clk);
    model_eval(e, age_n);
    exp_q.push_back(e);
    got = {hif.pc_write, hif.if_id_write, hif.if_id_flush,
           hif.id_ex_write, hif.id_ex_bubble, hif.mdu_busy};
    check(tag, 32'(got), 32'(exp_q.pop_front()));
    check({tag, "_stall"}, 32'(hif.stall_cycles), 32'(sat_cnt(raw, 16)));
    check({tag, "_stall_sat"}, 32'(sif.stall_cycles), 32'(sat_cnt(raw, SAT_W)));
    check({tag, "_state"}, 32'(hif.state_dbg), 32'(age > 0));
    if (!rst) raw = 0;
    else if (!e[5]) raw++;
    age = age_n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(NOOP_OP, 0, 0, 0, 0, 0);
    // reset: the controls are forced even when a load-use pattern is present
    cycle("reset");
    drive(LW_OP, 5, 5, 0, 0, 0);
    cycle("reset_forced");
    @(posedge clk); #1;
    rst = 1'b1;

    // load-use through rs: one stall cycle, then free flow
    drive(LW_OP, 5, 5, 0, 0, 0);  cycle("lu_rs");
    drive(ADD_OP, 5, 5, 0, 0, 0); cycle("lu_after");
    // rt is not used, rd is 0, or NOOP is in EX: no stall. Used rt: stall.
    drive(LW_OP, 5, 3, 5, 0, 0);  cycle("lu_rt_unused");
    drive(LW_OP, 0, 0, 0, 1, 0);  cycle("lu_rd0");
    drive(NOOP_OP, 5, 5, 5, 1, 0); cycle("noop");
    drive(LW_OP, 5, 1, 5, 1, 0);  cycle("lu_rt_used");

    // single MDU op
    drive(MDU_OP, 2, 0, 0, 0, 0);
    repeat (MDU_CYCLES) cycle("mdu");
    drive(ADD_OP, 0, 0, 0, 0, 0); cycle("mdu_done");

    // a branch beats a load-use match, and also beats an MDU op in EX
    drive(LW_OP, 5, 5, 5, 1, 1);  cycle("br_vs_lu");
    drive(MDU_OP, 2, 0, 0, 0, 1); cycle("br_vs_mdu");

    // back-to-back MDU ops, then reset in the middle of the second one
    drive(MDU_OP, 2, 0, 0, 0, 0);
    repeat (MDU_CYCLES + 2) cycle("mdu_b2b");
    rst = 1'b0;
    #1;
    check("rst_async", 32'({hif.pc_write, hif.if_id_write, hif.if_id_flush,
                            hif.id_ex_write, hif.id_ex_bubble, hif.mdu_busy}), 32'(O_PASS));
    check("rst_async_stall", 32'(hif.stall_cycles), 32'd0);
    check("rst_async_state", 32'(hif.state_dbg), 32'd0);
    age = 0; raw = 0;
    cycle("in_reset");
    rst = 1'b1;
    drive(ADD_OP, 0, 0, 0, 0, 0); cycle("after_reset");

    // saturation of the narrow counter under a held load-use stall
    drive(LW_OP, 7, 7, 0, 0, 0);
    repeat ((1 << SAT_W) + 3) cycle("sat");
    drive(ADD_OP, 0, 0, 0, 0, 0); cycle("sat_end");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       op = LW_OP;
      else if (r == 4) op = MDU_OP;
      else if (r == 5) op = NOOP_OP;
      else             op = ADD_OP;
      drive(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
